// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding and
// byte-lane helper.
package mem_arbiter_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   function automatic int byte_lanes(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational picker: rotating priority starting after last_grant when mode=1,
// plain lowest-index-first when mode=0.
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   input  logic          mode,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);

   int            pos;
   logic [IW-1:0] p_idx;
   logic          found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      p_idx = '0;
      for (int k = 0; k < N; k++) begin
         pos   = mode ? (int'(last_grant) + 1 + k) % N : k;
         p_idx = IW'(pos);
         if (!found && req[p_idx]) begin
            found        = 1'b1;
            grant[p_idx] = 1'b1;
            idx          = p_idx;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-port memory arbiter: IDLE picks a requester and latches its access,
// ACCESS holds the bus until mem_ready, RESP pulses that requester's ack.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int NUM_PORTS   = 2,
   parameter int ADDR_WIDTH  = 30,
   parameter int DATA_WIDTH  = 32,
   parameter int ROUND_ROBIN = 1
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic [NUM_PORTS-1:0]                        req_re,
   input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]         req_we,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]             req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]             req_wdata,
   output logic [NUM_PORTS-1:0]                        ack,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]             rsp_rdata,
   output logic [ADDR_WIDTH-1:0]                       addr,
   output logic                                        re,
   output logic [DATA_WIDTH/8-1:0]                     we,
   output logic [DATA_WIDTH-1:0]                       wdata,
   input  logic [DATA_WIDTH-1:0]                       rdata,
   input  logic                                        mem_ready
);

   localparam int NB = byte_lanes(DATA_WIDTH);
   localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   // Handshake: a port requests by holding req_re/req_we (plus addr/wdata)
   // stable; the arbiter answers with a single-cycle ack, after which the
   // port must drop or change its request in the following cycle.
   logic [1:0]            state;
   logic [IW-1:0]         win_idx;
   logic [IW-1:0]         last_grant;
   logic [IW-1:0]         pick_idx;
   logic [NUM_PORTS-1:0]  win_oh;
   logic [NUM_PORTS-1:0]  pick_grant;
   logic [NUM_PORTS-1:0]  req_any;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [NB-1:0]         lat_we;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic                  lat_re;
   logic [NB-1:0]         sel_we;
   logic [DATA_WIDTH-1:0] rsp_q [NUM_PORTS];

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      assign req_any[i] = req_re[i] | (|req_we[i*NB +: NB]);
      assign rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = rsp_q[i];
   end

   assign sel_we = req_we[int'(pick_idx)*NB +: NB];

   rr_pick #(
      .N  (NUM_PORTS),
      .IW (IW)
   ) u_pick (
      .req        (req_any),
      .last_grant (last_grant),
      .mode       (ROUND_ROBIN != 0),
      .grant      (pick_grant),
      .idx        (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         last_grant <= IW'(NUM_PORTS - 1);
         win_idx    <= '0;
         win_oh     <= '0;
         lat_addr   <= '0;
         lat_we     <= '0;
         lat_wdata  <= '0;
         lat_re     <= 1'b0;
         for (int i = 0; i < NUM_PORTS; i++) rsp_q[i] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|req_any) begin
                  state      <= ST_ACCESS;
                  win_idx    <= pick_idx;
                  win_oh     <= pick_grant;
                  last_grant <= pick_idx;
                  lat_addr   <= req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                  lat_wdata  <= req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                  lat_we     <= sel_we;
                  // A combined read+write request is carried out as a write.
                  lat_re     <= req_re[pick_idx] & ~(|sel_we);
               end
            end
            ST_ACCESS: begin
               if (mem_ready) begin
                  if (lat_re) rsp_q[win_idx] <= rdata;
                  state <= ST_RESP;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      addr  = '0;
      re    = 1'b0;
      we    = '0;
      wdata = '0;
      ack   = '0;
      if (state == ST_ACCESS) begin
         addr  = lat_addr;
         re    = lat_re;
         we    = lat_we;
         wdata = lat_wdata;
      end
      if (state == ST_RESP) ack = win_oh;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance share bus
// stimulus; acks are scored against per-instance expected queues.
module tb_mem_arbiter;

   localparam int EW = 36;  // {is_read, port[2:0], rdata[31:0]}

   logic        clk;
   logic        reset;
   logic [1:0]  req_re_rr, req_re_fx;
   logic [7:0]  req_we;
   logic [59:0] req_addr;
   logic [63:0] req_wdata;
   logic [31:0] rdata;
   logic        mem_ready;

   logic [1:0]  ack_rr, ack_fx;
   logic [63:0] rsp_rr, rsp_fx;
   logic [29:0] addr_rr, addr_fx;
   logic        re_rr, re_fx;
   logic [3:0]  we_rr, we_fx;
   logic [31:0] wdata_rr, wdata_fx;

   logic [EW-1:0] exp_rr[$];
   logic [EW-1:0] exp_fx[$];
   int n_tests = 0;
   int n_fail  = 0;

   mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(30), .DATA_WIDTH(32), .ROUND_ROBIN(1)) u_rr (
      .clk(clk), .reset(reset), .req_re(req_re_rr), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .ack(ack_rr), .rsp_rdata(rsp_rr), .addr(addr_rr), .re(re_rr),
      .we(we_rr), .wdata(wdata_rr), .rdata(rdata), .mem_ready(mem_ready)
   );

   mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(30), .DATA_WIDTH(32), .ROUND_ROBIN(0)) u_fx (
      .clk(clk), .reset(reset), .req_re(req_re_fx), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .ack(ack_fx), .rsp_rdata(rsp_fx), .addr(addr_fx), .re(re_fx),
      .we(we_fx), .wdata(wdata_fx), .rdata(rdata), .mem_ready(mem_ready)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // scoreboard: every ack pops the oldest expectation of its instance
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (ack_rr != 2'b00) begin
         check("rr_ack_onehot", 64'($countones(ack_rr)), 64'd1);
         if (exp_rr.size() == 0) check("rr_ack_unexpected", 64'(ack_rr), 64'd0);
         else begin
            e = exp_rr.pop_front();
            check("rr_ack_port", 64'(ack_rr), 64'd1 << e[34:32]);
            if (e[35]) check("rr_rsp_rdata", 64'(rsp_rr[int'(e[34:32])*32 +: 32]), 64'(e[31:0]));
         end
      end
      if (ack_fx != 2'b00) begin
         check("fx_ack_onehot", 64'($countones(ack_fx)), 64'd1);
         if (exp_fx.size() == 0) check("fx_ack_unexpected", 64'(ack_fx), 64'd0);
         else begin
            e = exp_fx.pop_front();
            check("fx_ack_port", 64'(ack_fx), 64'd1 << e[34:32]);
            if (e[35]) check("fx_rsp_rdata", 64'(rsp_fx[int'(e[34:32])*32 +: 32]), 64'(e[31:0]));
         end
      end
   end

   // One access on port p, entered at posedge+1 in IDLE; late_addr replaces the
   // request address from the second ACCESS cycle on.
   task automatic do_access(input int p, input logic rd, input logic [3:0] wen,
                            input logic [29:0] a, input logic [31:0] wd,
                            input logic [31:0] rd_val, input int waits,
                            input logic [29:0] late_addr);
      logic exp_re;
      exp_re = rd && (wen == 4'b0000);
      req_re_rr[p] = rd;
      req_re_fx[p] = rd;
      req_we[p*4 +: 4]     = wen;
      req_addr[p*30 +: 30] = a;
      req_wdata[p*32 +: 32] = wd;
      rdata     = rd_val;
      mem_ready = (waits == 0);
      exp_rr.push_back({exp_re, 3'(p), rd_val});
      exp_fx.push_back({exp_re, 3'(p), rd_val});
      @(negedge clk);
      check("idle_re", 64'(re_rr), 64'd0);
      for (int w = 0; w <= waits; w++) begin
         @(posedge clk); #1;
         mem_ready = (w == waits);
         if (w == 1) req_addr[p*30 +: 30] = late_addr;
         @(negedge clk);
         check("acc_addr", 64'(addr_rr), 64'(a));
         check("acc_re", 64'(re_rr), 64'(exp_re));
         check("acc_we", 64'(we_rr), 64'(wen));
         check("acc_wdata", 64'(wdata_rr), 64'(wd));
         check("fx_acc_addr", 64'(addr_fx), 64'(a));
      end
      @(posedge clk); #1;
      req_re_rr[p] = 1'b0;
      req_re_fx[p] = 1'b0;
      req_we[p*4 +: 4] = 4'b0000;
      mem_ready = 1'b1;
      @(negedge clk);
      check("ack_cycle", 64'(ack_rr), 64'd1 << p);
      check("resp_bus_idle", 64'({re_rr, we_rr}), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int n_rr, n_fx;
      bit done;
      reset = 1'b1;
      req_re_rr = '0; req_re_fx = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      rdata = '0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_ack_rr", 64'(ack_rr), 64'd0);
      check("rst_ack_fx", 64'(ack_fx), 64'd0);
      check("rst_bus", 64'({re_rr, we_rr, addr_rr}), 64'd0);
      check("rst_wdata", 64'(wdata_rr), 64'd0);
      check("rst_rsp", rsp_rr, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // single zero-wait read, then a write with three wait states
      do_access(0, 1'b1, 4'b0000, 30'h10, 32'h0, 32'hDEADBEEF, 0, 30'h10);
      check("t1_rsp0", 64'(rsp_rr[31:0]), 64'hDEADBEEF);
      check("t1_rsp1", 64'(rsp_rr[63:32]), 64'd0);
      do_access(1, 1'b0, 4'b0011, 30'h3, 32'h12345678, 32'hFFFFFFFF, 3, 30'h3);
      check("t2_rsp1", 64'(rsp_rr[63:32]), 64'd0);
      check("t2_rsp0", 64'(rsp_rr[31:0]), 64'hDEADBEEF);

      // read on port 1 with waits; read+write treated as write
      do_access(1, 1'b1, 4'b0000, 30'h7, 32'h0, 32'hCAFEF00D, 2, 30'h7);
      check("rd1_rsp0", 64'(rsp_rr[31:0]), 64'hDEADBEEF);
      do_access(0, 1'b1, 4'b1111, 30'h8, 32'hA5A5A5A5, 32'h11111111, 1, 30'h8);
      check("rw_rsp0", 64'(rsp_fx[31:0]), 64'hDEADBEEF);

      // request address changed after grant
      do_access(0, 1'b1, 4'b0000, 30'h20, 32'h0, 32'h600DF00D, 2, 30'h40);

      // reset during the second ACCESS cycle of a port 0 read
      req_re_rr = 2'b01; req_re_fx = 2'b01;
      req_addr[29:0] = 30'h50; mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      req_re_rr = 2'b00; req_re_fx = 2'b00; mem_ready = 1'b1;
      @(negedge clk);
      check("mid_rst_re", 64'(re_rr), 64'd0);
      check("mid_rst_ack", 64'({ack_rr, ack_fx}), 64'd0);
      check("mid_rst_rsp_rr", rsp_rr, 64'd0);
      check("mid_rst_rsp_fx", rsp_fx, 64'd0);
      @(posedge clk); #1;

      // contention: both ports request continuously
      req_addr = {30'h200, 30'h100};
      rdata = 32'h0BADF00D;
      req_re_rr = 2'b11; req_re_fx = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_rr.push_back({1'b1, 3'(k % 2), 32'h0BADF00D});
         exp_fx.push_back({1'b1, 3'd0, 32'h0BADF00D});
      end
      n_rr = 0; n_fx = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (ack_rr != 2'b00) begin
            n_rr++;
            if (n_rr == 4) req_re_rr = 2'b00;
         end
         if (ack_fx != 2'b00) begin
            n_fx++;
            if (n_fx == 4) begin
               req_re_fx = 2'b10;
               exp_fx.push_back({1'b1, 3'd1, 32'h0BADF00D});
            end
            if (n_fx == 5) req_re_fx = 2'b00;
         end
         done = (n_rr >= 4) && (n_fx >= 5);
      end
      check("cont_rr_acks", 64'(n_rr), 64'd4);
      check("cont_fx_acks", 64'(n_fx), 64'd5);

      repeat (4) @(posedge clk);
      #1;
      check("rr_queue_empty", 64'(exp_rr.size()), 64'd0);
      check("fx_queue_empty", 64'(exp_fx.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
